clk_align_scheduler: RTL and testbench
======================================

Name: clk_align_scheduler

Overview:
- Synthesizable clock-enable scheduler that derives several divided, edge-aligned clock/strobe channels from one base clock.
- Each channel has its own runtime divide ratio. All channels start from a common epoch, so their rising edges coincide at start and at every common multiple of their periods.
- Sits beside the base clock and sequences downstream slow-domain logic through enables rather than generated clocks.
- Provides a start/stop handshake and a graceful drain on stop.

Parameters:
- NUM_CH, 3, number of divided channels.
- DIVW, 8, width of each channel's divide ratio.

Ports:
- clk  in  1  base clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin; sampled only in IDLE.
- stop  in  1  single-cycle request to stop; sampled only in RUN.
- div_cfg  in  NUM_CH*DIVW  divide ratio per channel; channel i uses bits [i*DIVW +: DIVW].
- busy  out  1  high in ALIGN, RUN, DRAIN.
- running  out  1  high in RUN only.
- done  out  1  one-cycle pulse when DRAIN completes.
- cfg_err  out  1  sticky; set if any latched ratio is below 2; cleared on the next start.
- div_clk  out  NUM_CH  divided square waves.
- en_pulse  out  NUM_CH  one-cycle strobe at each divided rising edge.
- all_aligned  out  1  high in cycles where every active channel has en_pulse high.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE; all outputs 0; counters 0; latched ratios 0.
  - Reset has priority over everything, including mid-RUN and mid-DRAIN, and drops all outputs to 0 on the next edge.
- IDLE:
  - start=1 -> ALIGN.
  - start and stop both high -> start wins.
  - All outputs 0 except a sticky cfg_err.
- ALIGN (exactly 1 cycle):
  - Latch div_cfg into div_q[i]. Ratios 0 or 1 clamp to 2 and set cfg_err; cfg_err is otherwise cleared here.
  - Load cnt[i]=0 for all channels.
  - Next state RUN.
  - stop is ignored in this state.
- RUN:
  - Per channel, cnt[i] counts 0..div_q[i]-1 and then wraps to 0.
  - div_clk[i]=1 while cnt[i] < floor(div_q[i]/2), else 0. High time is floor(N/2) cycles and low time is N-floor(N/2); odd N gives the longer low phase.
  - en_pulse[i]=1 exactly when cnt[i]==0.
  - Outputs are registered. The first RUN cycle (2 cycles after start was sampled) has every div_clk=1 and every en_pulse=1, and all_aligned=1.
  - div_cfg changes during RUN have no effect; the latched values rule.
  - stop=1 -> DRAIN. start is ignored.
- DRAIN:
  - Each channel continues counting until it completes its current period (cnt[i]==div_q[i]-1).
  - A finished channel then freezes: div_clk[i]=0, en_pulse[i]=0, and it issues no new rising edge.
  - A channel already at cnt==div_q-1 when DRAIN is entered freezes on the next cycle.
  - When all channels are frozen: assert done for 1 cycle, go to IDLE.
  - start and stop are ignored in DRAIN.
- all_aligned:
  - AND of en_pulse over channels not frozen.
  - Forced 0 outside RUN/DRAIN and 0 when no channel is active.
- Widths:
  - cnt[i] is DIVW bits.
  - Maximum ratio is 2^DIVW-1.
  - Wrap compare uses div_q[i]-1 with no overflow.

Test Plan:
- Reset and idle: hold rst 3 cycles, then idle 10 cycles -> all outputs 0, busy=0, done never pulses.
- Basic alignment: div_cfg={8,4,2} (ch2..ch0), pulse start at t -> ALIGN at t+1; at t+2 all div_clk=1, en_pulse=3'b111, all_aligned=1.
  - ch0 en_pulse every 2 cycles, ch1 every 4, ch2 every 8; all_aligned every 8 cycles.
  - div_clk duty is 1/1, 2/2 and 4/4 high/low cycles respectively.
- Odd ratio and clamp: div_cfg={5,1,0} -> cfg_err=1; ch0 and ch1 run as ratio 2; ch2 div_clk is high 2 cycles, low 3, with en_pulse every 5 cycles.
  - A next start with valid ratios clears cfg_err.
- Graceful stop: with {8,4,2} running, pulse stop when ch2 cnt=3 -> ch0 and ch1 freeze at their own period ends; ch2 freezes after cnt=7.
  - done pulses once, 1 cycle after the last freeze; state returns to IDLE.
  - No en_pulse occurs after a channel's freeze.
- Ignored requests and priority:
  - start during RUN: no effect.
  - stop during ALIGN: no effect; enters RUN.
  - start+stop together in IDLE: starts.
  - div_cfg changed mid-RUN: periods unchanged until the next start.
- Reset mid-operation: assert rst during DRAIN -> next edge all outputs 0, no done pulse. A start 1 cycle after rst deasserts aligns all channels normally.

Source files
------------

// File: rtl/clk_align_scheduler.sv
// Clock-enable scheduler: derives NUM_CH divided, edge-aligned square waves and
// strobes from one base clock, with a start/stop handshake and graceful drain.
module clk_align_scheduler #(
  parameter int NUM_CH = 3,
  parameter int DIVW   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [NUM_CH*DIVW-1:0] div_cfg,
  output logic                   busy,
  output logic                   running,
  output logic                   done,
  output logic                   cfg_err,
  output logic [NUM_CH-1:0]      div_clk,
  output logic [NUM_CH-1:0]      en_pulse,
  output logic                   all_aligned,
  output logic [1:0]             dbg_state
);

  // Request semantics: start and stop are single-cycle levels with no ready;
  // start is honoured only in IDLE (winning over stop there), stop only in RUN.
  // A request presented in any other state is dropped, never queued.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALIGN = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t state, state_next;

  logic [DIVW-1:0]   div_q  [NUM_CH];
  logic [DIVW-1:0]   div_d  [NUM_CH];
  logic [DIVW-1:0]   cnt_q  [NUM_CH];
  logic [DIVW-1:0]   cnt_d  [NUM_CH];
  logic [NUM_CH-1:0] frozen_q, frozen_d;
  logic [NUM_CH-1:0] at_end;
  logic [NUM_CH-1:0] bad_cfg;
  logic              done_q, done_d;
  logic              cfg_err_q, cfg_err_d;
  logic [NUM_CH-1:0] div_clk_q, div_clk_d;
  logic [NUM_CH-1:0] en_pulse_q, en_pulse_d;
  logic              all_aligned_q, all_aligned_d;
  logic              act_next;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_ALIGN;
      S_ALIGN: state_next = S_RUN;
      S_RUN:   if (stop) state_next = S_DRAIN;
      S_DRAIN: if (done_q) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (state != S_IDLE);
    running   = (state == S_RUN);
    done      = done_q;
    dbg_state = state;
  end

  // Per-channel counter datapath; ratios are latched only while aligning.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      bad_cfg[i]  = (div_cfg[i*DIVW +: DIVW] < DIVW'(2));
      at_end[i]   = (cnt_q[i] == div_q[i] - DIVW'(1));
      div_d[i]    = div_q[i];
      cnt_d[i]    = cnt_q[i];
      frozen_d[i] = frozen_q[i];
      case (state)
        S_ALIGN: begin
          div_d[i]    = bad_cfg[i] ? DIVW'(2) : div_cfg[i*DIVW +: DIVW];
          cnt_d[i]    = '0;
          frozen_d[i] = 1'b0;
        end
        S_RUN: begin
          cnt_d[i] = at_end[i] ? '0 : cnt_q[i] + DIVW'(1);
        end
        S_DRAIN: begin
          // Finish the current period, then hold without a new rising edge.
          if (!frozen_q[i]) begin
            if (at_end[i]) begin
              frozen_d[i] = 1'b1;
              cnt_d[i]    = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + DIVW'(1);
            end
          end
        end
        default: begin
          cnt_d[i]    = '0;
          frozen_d[i] = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cfg_err_d = cfg_err_q;
    if (state == S_ALIGN) cfg_err_d = |bad_cfg;
  end

  // Done pulses one cycle after the last channel froze; the FSM leaves on it.
  always_comb begin
    done_d = (state == S_DRAIN) && (&frozen_q) && !done_q;
  end

  // Channel outputs are computed from next-cycle values and registered.
  always_comb begin
    act_next = (state_next == S_RUN) || (state_next == S_DRAIN);
    for (int i = 0; i < NUM_CH; i++) begin
      div_clk_d[i]  = act_next && !frozen_d[i] && (cnt_d[i] < (div_d[i] >> 1));
      en_pulse_d[i] = act_next && !frozen_d[i] && (cnt_d[i] == '0);
    end
    all_aligned_d = act_next && !(&frozen_d) && (&(en_pulse_d | frozen_d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      frozen_q      <= '0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      div_clk_q     <= '0;
      en_pulse_q    <= '0;
      all_aligned_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      frozen_q      <= frozen_d;
      done_q        <= done_d;
      cfg_err_q     <= cfg_err_d;
      div_clk_q     <= div_clk_d;
      en_pulse_q    <= en_pulse_d;
      all_aligned_q <= all_aligned_d;
    end
  end

  assign cfg_err     = cfg_err_q;
  assign div_clk     = div_clk_q;
  assign en_pulse    = en_pulse_q;
  assign all_aligned = all_aligned_q;

endmodule

// File: tb/tb_clk_align_scheduler.sv
// Directed bench for clk_align_scheduler: expected output words are queued per
// cycle from a period/phase description of each channel and compared after each edge.
module tb_clk_align_scheduler;

  localparam int NUM_CH = 3;
  localparam int DIVW   = 8;
  localparam int W      = 11;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic                   stop;
  logic [NUM_CH*DIVW-1:0] div_cfg;
  logic                   busy, running, done, cfg_err, all_aligned;
  logic [NUM_CH-1:0]      div_clk, en_pulse;
  logic [1:0]             dbg_state;

  clk_align_scheduler #(.NUM_CH(NUM_CH), .DIVW(DIVW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .div_cfg     (div_cfg),
    .busy        (busy),
    .running     (running),
    .done        (done),
    .cfg_err     (cfg_err),
    .div_clk     (div_clk),
    .en_pulse    (en_pulse),
    .all_aligned (all_aligned),
    .dbg_state   (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // expectation model: channel ratios, stop point and per-channel freeze cycle
  int   n[NUM_CH];
  int   freeze[NUM_CH];
  int   stop_k;
  int   done_k;
  logic exp_err;

  function automatic logic [W-1:0] pack(input logic b, input logic r, input logic d,
                                        input logic e, input logic a,
                                        input logic [2:0] en, input logic [2:0] dc);
    return {b, r, d, e, a, en, dc};
  endfunction

  // Each channel freezes right after finishing the period it is in once DRAIN begins.
  task automatic compute_freeze();
    int last;
    last = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      freeze[i] = 1 << 30;
      for (int k = stop_k + n[i]; k >= stop_k + 1; k--)
        if (k % n[i] == n[i] - 1) freeze[i] = k + 1;
      if (freeze[i] > last) last = freeze[i];
    end
    done_k = last + 1;
  endtask

  // Expected outputs for the k-th cycle after the first RUN cycle.
  function automatic logic [W-1:0] exp_run(input int k);
    logic [2:0] act, en, dc;
    logic       al;
    int         m;
    for (int i = 0; i < NUM_CH; i++) begin
      m      = k % n[i];
      act[i] = (k < freeze[i]);
      en[i]  = act[i] && (m == 0);
      dc[i]  = act[i] && (m < n[i] / 2);
    end
    al = (|act) && ((en | ~act) == 3'b111);
    if (k > done_k)  return pack(0, 0, 0, exp_err, 0, 3'b000, 3'b000);
    if (k == done_k) return pack(1, 0, 1, exp_err, 0, 3'b000, 3'b000);
    return pack(1, k <= stop_k, 0, exp_err, al, en, dc);
  endfunction

  // driver: push expected, advance one edge, pop and compare away from the edge
  task automatic tick(input logic [W-1:0] e, input string tag);
    logic [W-1:0] got, want;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got  = {busy, running, done, cfg_err, all_aligned, en_pulse, div_clk};
    want = exp_q.pop_front();
    n_checks++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, got, want);
  endtask

  task automatic run_scenario(input logic [23:0] cfg, input int s_k,
                              input logic err_before, input logic err_after);
    stop_k = s_k;
    compute_freeze();
    div_cfg = cfg;
    start   = 1'b1;
    stop    = 1'b1;
    tick(pack(1, 0, 0, err_before, 0, 3'b000, 3'b000), "align");
    start   = 1'b0;
    stop    = 1'b1;
    exp_err = err_after;
    tick(exp_run(0), "run_first");
    for (int k = 0; k <= done_k; k++) begin
      start = (k == 5) || (k == stop_k + 2);
      stop  = (k == stop_k) || (k == stop_k + 1);
      if (k == 10) div_cfg = 24'h030103;
      tick(exp_run(k + 1), (k + 1 == done_k) ? "done" : "run");
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    div_cfg = '0;
    exp_err = 1'b0;

    for (int i = 0; i < 3; i++) tick('0, "reset");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick('0, "idle");

    // {8,4,2}, start+stop together, stop ignored in ALIGN, stop at ch2 cnt=3
    n[0] = 2; n[1] = 4; n[2] = 8;
    run_scenario(24'h080402, 19, 1'b0, 1'b0);

    // odd ratio 5 with two clamped channels
    n[0] = 2; n[1] = 2; n[2] = 5;
    run_scenario(24'h050100, 30, 1'b0, 1'b1);

    // valid restart clears cfg_err
    n[0] = 2; n[1] = 4; n[2] = 8;
    run_scenario(24'h080402, 11, 1'b1, 1'b0);

    // reset in the middle of DRAIN
    stop_k = 3;
    compute_freeze();
    exp_err = 1'b0;
    div_cfg = 24'h080402;
    start   = 1'b1;
    tick(pack(1, 0, 0, 0, 0, 3'b000, 3'b000), "align_rst");
    start = 1'b0;
    tick(exp_run(0), "run_first_rst");
    for (int k = 0; k <= 5; k++) begin
      stop = (k == 3);
      tick(exp_run(k + 1), "drain_rst");
    end
    stop = 1'b0;
    rst  = 1'b1;
    tick('0, "reset_mid");
    rst = 1'b0;
    tick('0, "after_reset");
    run_scenario(24'h080402, 11, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
